// File: rtl/divmod_arbiter.sv
// Two-requester front end for a shared multi-cycle divider. Requests are
// granted round-robin and each result is returned to the requester that asked.
module divmod_arbiter #(
   parameter int WIDTH   = 16,
   parameter int TIMEOUT = 40
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic             req1,
   input  logic             op0,
   input  logic             op1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             rsp_valid0,
   output logic             rsp_valid1,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   output logic             busy,
   output logic             unit_start,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   input  logic [WIDTH-1:0] unit_quot,
   input  logic [WIDTH-1:0] unit_rest,
   input  logic             unit_done
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t           state_q, state_d;
   logic             ptr_q, ptr_d;
   logic             id_q, id_d;
   logic             op_q, op_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             anyReq;
   logic             grantId;
   logic             selOp;
   logic [WIDTH-1:0] selA;
   logic [WIDTH-1:0] selB;
   logic             timeoutHit;

   // The pointer names the preferred requester; the other one wins only when
   // the preferred one is idle.
   always_comb begin
      anyReq     = req0 | req1;
      grantId    = ptr_q ? req1 : ~req0;
      selOp      = grantId ? op1 : op0;
      selA       = grantId ? a1 : a0;
      selB       = grantId ? b1 : b0;
      timeoutHit = (cnt_q == CW'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         id_q    <= 1'b0;
         op_q    <= 1'b0;
         err_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         op_q    <= op_d;
         err_q   <= err_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
      end
   end

   // A zero divisor never reaches the divider; it is answered directly with
   // an error. A done in the last wait cycle beats the timeout.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      id_d    = id_q;
      op_d    = op_q;
      err_d   = err_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (anyReq) begin
               ptr_d = ~grantId;
               id_d  = grantId;
               op_d  = selOp;
               a_d   = selA;
               b_d   = selB;
               cnt_d = '0;
               if (selB == '0) begin
                  state_d = RESP;
                  data_d  = '0;
                  err_d   = 1'b1;
               end else begin
                  state_d = ISSUE;
                  err_d   = 1'b0;
               end
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (unit_done) begin
               data_d  = op_q ? unit_rest : unit_quot;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timeoutHit) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grants are combinational so they land in the cycle the request is taken;
   // they are masked while reset is held.
   always_comb begin
      gnt0       = (state_q == IDLE) && anyReq && !grantId && !rst;
      gnt1       = (state_q == IDLE) && anyReq && grantId && !rst;
      rsp_valid0 = (state_q == RESP) && !id_q;
      rsp_valid1 = (state_q == RESP) && id_q;
      rsp_err    = (state_q == RESP) && err_q;
      rsp_data   = data_q;
      busy       = (state_q != IDLE);
      unit_start = (state_q == ISSUE);
      unit_a     = a_q;
      unit_b     = b_q;
   end

endmodule

// File: tb/tb_divmod_arbiter.sv
// Directed bench for divmod_arbiter with a behavioural divider that answers a
// programmable number of cycles after each start pulse.
module tb_divmod_arbiter;

   localparam int WIDTH   = 16;
   localparam int TIMEOUT = 40;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0, req1, op0, op1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic             gnt0, gnt1, rsp_valid0, rsp_valid1;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err, busy, unit_start;
   logic [WIDTH-1:0] unit_a, unit_b;
   logic [WIDTH-1:0] unit_quot = '0;
   logic [WIDTH-1:0] unit_rest = '0;
   logic             unit_done = 1'b0;

   int checks = 0;
   int passes = 0;
   int doneDelay = 17;
   int cyc = 0;
   int overlap = 0;

   int               gC, sC, rC, gId, rId, starts, rv0Seen;
   logic [WIDTH-1:0] rData;
   logic             rErr;

   divmod_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
      .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
      .unit_quot(unit_quot), .unit_rest(unit_rest), .unit_done(unit_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Divider model: ignores reset so a late done can arrive after an abort.
   int  left = 0;
   bit  pend = 0;
   always @(posedge clk) begin
      unit_done <= 1'b0;
      if (unit_start && doneDelay > 0) begin
         pend = 1;
         left = doneDelay;
         unit_quot <= unit_a / unit_b;
         unit_rest <= unit_a % unit_b;
      end
      if (pend) begin
         left = left - 1;
         if (left == 0) begin
            unit_done <= 1'b1;
            pend = 0;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic applyStimulus(input logic r0, input logic o0, input int av0, input int bv0,
                                input logic r1, input logic o1, input int av1, input int bv1);
      @(posedge clk);
      #1;
      req0 = r0; op0 = o0; a0 = WIDTH'(av0); b0 = WIDTH'(bv0);
      req1 = r1; op1 = o1; a1 = WIDTH'(av1); b1 = WIDTH'(bv1);
   endtask

   // Follows one transaction from grant to response, sampling on falling
   // edges; the served requester drops its req once its response is seen.
   task automatic runTxn(input int budget);
      gC = -1; sC = -1; rC = -1; gId = -1; rId = -1; starts = 0; rv0Seen = 0;
      rData = '1; rErr = 1'bx;
      for (int i = 0; i < budget && rC < 0; i++) begin
         @(negedge clk);
         if ((gnt0 && gnt1) || (rsp_valid0 && rsp_valid1)) overlap++;
         if ((gnt0 || gnt1) && gC < 0) begin
            gC  = cyc;
            gId = gnt1 ? 1 : 0;
         end
         if (unit_start) begin
            starts++;
            if (sC < 0) sC = cyc;
         end
         if (rsp_valid0) rv0Seen++;
         if (rsp_valid0 || rsp_valid1) begin
            rC    = cyc;
            rId   = rsp_valid1 ? 1 : 0;
            rData = rsp_data;
            rErr  = rsp_err;
            if (rsp_valid0) req0 = 1'b0;
            if (rsp_valid1) req1 = 1'b0;
         end
      end
   endtask

   initial begin
      int rvAfter;
      int busyAfter;
      rst = 1'b1;
      req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;

      repeat (2) @(negedge clk);
      req0 = 1; a0 = 100; b0 = 7;
      #1;
      checkOutput("rstGnt0", gnt0, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstStart", unit_start, 0);
      checkOutput("rstData", rsp_data, 0);
      checkOutput("rstUnitA", unit_a, 0);
      checkOutput("rstErr", rsp_err, 0);
      req0 = 0;
      @(posedge clk);
      #1 rst = 1'b0;

      doneDelay = 17;
      applyStimulus(1, 0, 100, 7, 0, 0, 0, 0);
      runTxn(100);
      checkOutput("q0Gnt", gId, 0);
      checkOutput("q0StartLat", sC - gC, 1);
      checkOutput("q0RspLat", rC - sC, 18);
      checkOutput("q0Id", rId, 0);
      checkOutput("q0Data", rData, 14);
      checkOutput("q0Err", rErr, 0);
      @(negedge clk);
      checkOutput("q0IdleAfter", busy, 0);

      applyStimulus(0, 0, 0, 0, 1, 1, 100, 7);
      runTxn(100);
      checkOutput("r1Id", rId, 1);
      checkOutput("r1Data", rData, 2);
      checkOutput("r1Err", rErr, 0);
      checkOutput("r1NoRv0", rv0Seen, 0);

      applyStimulus(1, 0, 50, 5, 1, 1, 50, 7);
      runTxn(100);
      checkOutput("pairAFirst", gId, 0);
      checkOutput("pairAData0", rData, 10);
      runTxn(100);
      checkOutput("pairASecond", gId, 1);
      checkOutput("pairAData1", rData, 1);
      applyStimulus(1, 1, 50, 7, 1, 0, 60, 4);
      runTxn(100);
      checkOutput("pairBFirst", gId, 0);
      checkOutput("pairBData0", rData, 1);
      runTxn(100);
      checkOutput("pairBSecond", gId, 1);
      checkOutput("pairBData1", rData, 15);

      applyStimulus(1, 0, 5, 0, 0, 0, 0, 0);
      runTxn(100);
      checkOutput("dz0Starts", starts, 0);
      checkOutput("dz0Lat", rC - gC, 1);
      checkOutput("dz0Id", rId, 0);
      checkOutput("dz0Data", rData, 0);
      checkOutput("dz0Err", rErr, 1);

      doneDelay = -1;
      applyStimulus(0, 0, 0, 0, 1, 0, 9, 3);
      runTxn(100);
      checkOutput("toLat", rC - sC, 41);
      checkOutput("toId", rId, 1);
      checkOutput("toData", rData, 0);
      checkOutput("toErr", rErr, 1);

      doneDelay = 40;
      applyStimulus(1, 1, 10, 3, 0, 0, 0, 0);
      runTxn(100);
      checkOutput("edgeLat", rC - sC, 41);
      checkOutput("edgeData", rData, 1);
      checkOutput("edgeErr", rErr, 0);

      doneDelay = 10;
      applyStimulus(1, 0, 20, 4, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
      checkOutput("preRstBusy", busy, 1);
      rst = 1'b1;
      req0 = 0;
      #1;
      checkOutput("midRstBusy", busy, 0);
      checkOutput("midRstUnitB", unit_b, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      rvAfter = 0;
      busyAfter = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (rsp_valid0 || rsp_valid1) rvAfter++;
         if (busy) busyAfter++;
      end
      checkOutput("lateDoneNoRsp", rvAfter, 0);
      checkOutput("lateDoneIdle", busyAfter, 0);

      doneDelay = 3;
      applyStimulus(1, 0, 30, 6, 1, 0, 30, 5);
      runTxn(100);
      checkOutput("ptrRstFirst", gId, 0);
      checkOutput("ptrRstData", rData, 5);
      runTxn(100);
      checkOutput("ptrRstSecond", gId, 1);
      checkOutput("ptrRstData1", rData, 6);

      checkOutput("oneHot", overlap, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/divmod_arbiter.md
DIVMOD_ARBITER -- requirements
Module: divmod_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, operand and result width.
REQ-002 Parameter: TIMEOUT, 40, maximum cycles spent in WAIT before a forced error response.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: req0, req1  input  1 each  request from requester 0 / 1; held high until that requester's rsp_valid.
REQ-006 Port: op0, op1  input  1 each  0 = quotient, 1 = remainder.
REQ-007 Port: a0, b0, a1, b1  input  WIDTH each  dividend / divisor per requester.
REQ-008 Port: gnt0, gnt1  output  1 each  one-cycle pulse when a request is accepted.
REQ-009 Port: rsp_valid0, rsp_valid1  output  1 each  one-cycle pulse when the result for that requester is available.
REQ-010 Port: rsp_data  output  WIDTH  result shared by both requesters; valid only while a rsp_valid is high.
REQ-011 Port: rsp_err  output  1  qualifies rsp_data: divide-by-zero or timeout.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: unit_start  output  1  one-cycle start pulse to the shared divider.
REQ-014 Port: unit_a, unit_b  output  WIDTH each  registered operands to the divider.
REQ-015 Port: unit_quot, unit_rest  input  WIDTH each  divider quotient / remainder.
REQ-016 Port: unit_done  input  1  divider completion.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-018 In IDLE with any req high, the block SHALL grant one requester, pulse its gnt, latch its op, a and b, latch its id, and go to ISSUE; the only exception is divide-by-zero (REQ-023).
REQ-019 Arbitration SHALL be round-robin: a pointer names the preferred requester; after each grant the pointer moves to the other requester; pointer reset value is 0.
REQ-020 ISSUE SHALL last one cycle with unit_start=1, then the FSM SHALL go to WAIT; unit_a and unit_b SHALL hold the latched operands from ISSUE until return to IDLE.
REQ-021 In WAIT, a cycle counter SHALL increment each cycle; unit_done=1 SHALL capture unit_quot (op=0) or unit_rest (op=1) into rsp_data with rsp_err=0, and the FSM SHALL go to RESP.
REQ-022 If the counter reaches TIMEOUT without unit_done, the block SHALL go to RESP with rsp_data=0 and rsp_err=1.
REQ-023 A granted operand pair with b==0 SHALL bypass the divider: no unit_start; the FSM goes IDLE->RESP; rsp_data=0; rsp_err=1.
REQ-024 RESP SHALL last one cycle, pulse rsp_valid for the latched id only, then return to IDLE.
REQ-025 Latency: grant at cycle T, unit_start at T+1, done at cycle D, rsp_valid at D+1, IDLE at D+2; for divide-by-zero, rsp_valid at T+1.
REQ-026 Requests SHALL be sampled only in IDLE; req changes in the other states are ignored.
REQ-027 unit_done outside WAIT SHALL be ignored.
REQ-028 When unit_done arrives in the same cycle the counter reaches TIMEOUT, unit_done SHALL take priority: normal result, rsp_err=0.
REQ-029 Requesters SHALL deassert req the cycle after their rsp_valid; a req still high in IDLE is treated as a new request.
REQ-030 At most one gnt, and at most one rsp_valid, SHALL be high in any cycle.

Reset
REQ-031 While rst is high, the FSM SHALL be in IDLE and the pointer SHALL be 0.
REQ-032 While rst is high, gnt0/1, rsp_valid0/1, rsp_err, busy and unit_start SHALL be 0, and rsp_data, unit_a, unit_b and the counter SHALL be 0.
REQ-033 Assertion of rst mid-operation SHALL abort the operation immediately, with no response pulse for the aborted operation.
REQ-034 After rst deasserts, a late unit_done SHALL be ignored.

Verification
REQ-035 Single request: req0=1, op0=0, a0=100, b0=7; divider done 17 cycles after start -> gnt0 at T, unit_start at T+1, rsp_valid0 with rsp_data=14 and rsp_err=0 at done+1.
REQ-036 Remainder: req1=1, op1=1, a1=100, b1=7 -> rsp_valid1 with rsp_data=2 and rsp_err=0; rsp_valid0 stays 0.
REQ-037 Contention: req0 and req1 high together from reset -> requester 0 served first, then requester 1; next simultaneous pair -> requester 0 first again (pointer alternates).
REQ-038 Divide-by-zero: req0=1, a0=5, b0=0 -> unit_start never pulses; rsp_valid0=1, rsp_data=0, rsp_err=1 one cycle after gnt0.
REQ-039 Timeout: the divider never asserts unit_done -> rsp_valid at cycle start+1+TIMEOUT with rsp_err=1 and rsp_data=0; unit_done simultaneous with the TIMEOUT count -> rsp_err=0.
REQ-040 Reset in WAIT: rst pulsed, then unit_done -> no rsp_valid, busy=0, pointer=0.
